divmmc_spi_arbiter: RTL and testbench
=====================================

# divmmc_spi_arbiter

Shares the single SD-card SPI bus between two requesters and owns the only SPI shift engine in the design. Requester 0 is the Z80-side DivMMC port logic; requester 1 is the boot/sector loader. The block arbitrates bus ownership per locked session, routes the owner's chip-select, and performs 8-bit mode-0 transfers at a programmable SCK rate.

## Interface
Parameters:
- CLK_DIV, 2: SCK half-period in clk_sys cycles; legal range 1..255.

Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_lock, p1_lock  in  1  requester holds the bus while high.
- p0_cs_n, p1_cs_n  in  1  requester's desired SD chip-select, active low.
- p0_start, p1_start  in  1  one-cycle pulse; starts a byte transfer.
- p0_txd, p1_txd  in  8  byte to send; sampled on the start edge.
- p0_rxd, p1_rxd  out  8  last received byte; reset 0.
- p0_done, p1_done  out  1  one-cycle completion pulse; reset 0.
- p0_gnt, p1_gnt  out  1  requester owns the bus; reset 0.
- busy  out  1  shift engine active; reset 0.
- spi_ss  out  1  SD chip-select; reset 1.
- spi_clk  out  1  SCK; reset 0.
- spi_do  out  1  MOSI; reset 1; idles at 1.
- spi_di  in  1  MISO.

## Operation
- Arbiter states:
  - FREE: no grant; spi_ss=1.
  - OWN0 / OWN1: the corresponding gnt=1; spi_ss follows that owner's cs_n combinationally.
  - RELEASE: one cycle; no grant; spi_ss=1.
- FREE -> OWN1 if p1_lock=1; else FREE -> OWN0 if p0_lock=1. When both locks are asserted on the same edge, requester 1 wins.
- OWNx -> RELEASE when px_lock=0 and busy=0. If the lock drops mid-transfer, the transfer finishes, px_done pulses, and the grant is released on the following edge.
- RELEASE -> FREE unconditionally. A requester still holding its lock is re-arbitrated from FREE.
- Start handling:
  - px_start is accepted only when px_gnt=1 and busy=0.
  - All other starts are dropped silently: no done pulse and no state change.
- Shift engine:
  - SPI mode 0, MSB first.
  - States: IDLE, LOW, HIGH, with an 8-bit phase counter and a 3-bit bit index.
  - On the accept edge: busy<=1; spi_do<=txd[7]; state LOW for CLK_DIV cycles with spi_clk=0.
  - LOW -> HIGH: spi_clk<=1. HIGH lasts CLK_DIV cycles. spi_di is shifted into the receive register on the last edge of HIGH.
  - HIGH -> LOW (bits 0..6): spi_clk<=0; spi_do<=next bit.
  - After bit 7's HIGH: spi_clk<=0; spi_do<=1; busy<=0; the owner's rxd<=received byte; the owner's done<=1; state IDLE.
- The non-owner's rxd holds its previous value.
- px_txd is latched on the accept edge; later changes have no effect.

## Timing
- Grant latency: lock sampled high at edge T in FREE -> gnt=1 from T+1.
- Release: lock low at edge T (engine idle) -> RELEASE at T+1, FREE at T+2, regrant at the earliest T+3.
- Transfer: start accepted at edge T.
  - First SCK rise at T+CLK_DIV.
  - Done pulse and valid rxd in the cycle following edge T+16·CLK_DIV.
  - busy falls at that same edge.
  - The next start can be accepted at edge T+16·CLK_DIV+1, which gives back-to-back bytes every 16·CLK_DIV+1 cycles.
- spi_ss has zero-cycle latency from the owner's cs_n. It never glitches low during RELEASE or FREE.
- Reset asserted mid-transfer: all outputs return to their reset values immediately. The engine goes to IDLE and the arbiter to FREE. No done pulse is issued.

## Test plan
- CLK_DIV=2, p0 locked, cs_n=0, start with txd=8'hA5, spi_di looped from spi_do:
  - spi_do shows bits 1,0,1,0,0,1,0,1.
  - 8 SCK pulses, each 2 cycles high and 2 cycles low.
  - p0_done pulses 32 cycles after start; p0_rxd=8'hA5.
- p0_lock and p1_lock raised on the same edge: p1_gnt=1 and p0_gnt=0. When p1 drops its lock, there is one RELEASE cycle with spi_ss=1, then p0_gnt=1 two cycles later.
- p0 pulses start while p1 owns the bus, or while busy=1: no SCK activity, no done pulse, and p0_rxd unchanged.
- p1 drops its lock during bit 3 of a transfer with spi_di tied to 0: the transfer completes, p1_done pulses with p1_rxd=8'h00, then RELEASE.
- Reset asserted during bit 5 of a transfer: spi_clk=0, spi_do=1, spi_ss=1, busy=0, both gnt=0, and no done pulse. After reset deasserts, a fresh transfer with txd=8'h3C and loopback returns rxd=8'h3C.
- CLK_DIV=1, two back-to-back accepted starts: done pulses exactly 17 cycles apart.

Source files
------------

// File: rtl/divmmc_spi_arbiter.sv
// Shares the SD-card SPI bus between the DivMMC port (req 0) and the boot loader (req 1).
// Per-session locked arbitration, owner chip-select routing, and 8-bit mode-0 MSB-first transfers.
module divmmc_spi_arbiter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       p0_lock,
    input  logic       p1_lock,
    input  logic       p0_cs_n,
    input  logic       p1_cs_n,
    input  logic       p0_start,
    input  logic       p1_start,
    input  logic [7:0] p0_txd,
    input  logic [7:0] p1_txd,
    output logic [7:0] p0_rxd,
    output logic [7:0] p1_rxd,
    output logic       p0_done,
    output logic       p1_done,
    output logic       p0_gnt,
    output logic       p1_gnt,
    output logic       busy,
    output logic       spi_ss,
    output logic       spi_clk,
    output logic       spi_do,
    input  logic       spi_di
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [1:0] {ARB_FREE, ARB_OWN0, ARB_OWN1, ARB_RELEASE} arb_state_t;
    typedef enum logic [1:0] {ENG_IDLE, ENG_LOW, ENG_HIGH} eng_state_t;

    arb_state_t arb, arb_nxt;
    eng_state_t eng, eng_nxt;

    logic [7:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_nxt;
    logic [7:0] tx, tx_nxt;
    logic [7:0] rx, rx_nxt;
    logic       owner, owner_nxt;
    logic       busy_nxt, sclk_nxt, do_nxt;
    logic [7:0] rxd0_nxt, rxd1_nxt;
    logic       done0_nxt, done1_nxt;
    logic       accept0, accept1;

    // Arbiter: requester 1 has priority when both locks arrive together
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) arb <= ARB_FREE;
        else       arb <= arb_nxt;
    end

    always_comb begin
        arb_nxt = arb;
        case (arb)
            ARB_FREE: begin
                if (p1_lock)      arb_nxt = ARB_OWN1;
                else if (p0_lock) arb_nxt = ARB_OWN0;
            end
            ARB_OWN0:    if (!p0_lock && !busy) arb_nxt = ARB_RELEASE;
            ARB_OWN1:    if (!p1_lock && !busy) arb_nxt = ARB_RELEASE;
            ARB_RELEASE: arb_nxt = ARB_FREE;
            default:     arb_nxt = ARB_FREE;
        endcase
    end

    assign p0_gnt = (arb == ARB_OWN0);
    assign p1_gnt = (arb == ARB_OWN1);

    // Chip-select is a pure mux of the owner's request so it tracks with no delay
    always_comb begin
        spi_ss = 1'b1;
        if (arb == ARB_OWN0)      spi_ss = p0_cs_n;
        else if (arb == ARB_OWN1) spi_ss = p1_cs_n;
    end

    assign accept0 = p0_gnt && p0_start && !busy;
    assign accept1 = p1_gnt && p1_start && !busy;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            eng     <= ENG_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= 8'hFF;
            rx      <= '0;
            owner   <= 1'b0;
            busy    <= 1'b0;
            spi_clk <= 1'b0;
            spi_do  <= 1'b1;
            p0_rxd  <= '0;
            p1_rxd  <= '0;
            p0_done <= 1'b0;
            p1_done <= 1'b0;
        end else begin
            eng     <= eng_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_nxt;
            tx      <= tx_nxt;
            rx      <= rx_nxt;
            owner   <= owner_nxt;
            busy    <= busy_nxt;
            spi_clk <= sclk_nxt;
            spi_do  <= do_nxt;
            p0_rxd  <= rxd0_nxt;
            p1_rxd  <= rxd1_nxt;
            p0_done <= done0_nxt;
            p1_done <= done1_nxt;
        end
    end

    always_comb begin
        eng_nxt   = eng;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        tx_nxt    = tx;
        rx_nxt    = rx;
        owner_nxt = owner;
        busy_nxt  = busy;
        sclk_nxt  = spi_clk;
        do_nxt    = spi_do;
        rxd0_nxt  = p0_rxd;
        rxd1_nxt  = p1_rxd;
        done0_nxt = 1'b0;
        done1_nxt = 1'b0;
        case (eng)
            ENG_IDLE: begin
                if (accept0 || accept1) begin
                    tx_nxt    = accept1 ? p1_txd : p0_txd;
                    do_nxt    = tx_nxt[7];
                    owner_nxt = accept1;
                    busy_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                    eng_nxt   = ENG_LOW;
                end
            end
            ENG_LOW: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt  = '0;
                    sclk_nxt = 1'b1;
                    eng_nxt  = ENG_HIGH;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            ENG_HIGH: begin
                if (cnt == DIV_LAST) begin
                    cnt_nxt  = '0;
                    sclk_nxt = 1'b0;
                    rx_nxt   = {rx[6:0], spi_di};
                    if (bit_idx == 3'd7) begin
                        do_nxt   = 1'b1;
                        busy_nxt = 1'b0;
                        eng_nxt  = ENG_IDLE;
                        if (owner) begin
                            rxd1_nxt  = rx_nxt;
                            done1_nxt = 1'b1;
                        end else begin
                            rxd0_nxt  = rx_nxt;
                            done0_nxt = 1'b1;
                        end
                    end else begin
                        // tx shifts left so bit 6 is always the next one out
                        do_nxt  = tx[6];
                        tx_nxt  = {tx[6:0], 1'b1};
                        bit_nxt = bit_idx + 3'd1;
                        eng_nxt = ENG_LOW;
                    end
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            default: eng_nxt = ENG_IDLE;
        endcase
    end

endmodule

// File: tb/tb_divmmc_spi_arbiter.sv
// Directed bench: CLK_DIV=2 instance for arbitration/transfer cases, CLK_DIV=1 instance for back-to-back timing.
module tb_divmmc_spi_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A, CLK_DIV = 2
    logic       a_p0_lock = 0, a_p1_lock = 0, a_p0_cs_n = 1, a_p1_cs_n = 1;
    logic       a_p0_start = 0, a_p1_start = 0;
    logic [7:0] a_p0_txd = 0, a_p1_txd = 0;
    logic [7:0] a_p0_rxd, a_p1_rxd;
    logic       a_p0_done, a_p1_done, a_p0_gnt, a_p1_gnt, a_busy;
    logic       a_ss, a_clk, a_do, a_di;
    logic       a_loop = 1;
    assign a_di = a_loop ? a_do : 1'b0;

    divmmc_spi_arbiter #(.CLK_DIV(2)) dut_a (
        .clk_sys(clk), .reset(reset),
        .p0_lock(a_p0_lock), .p1_lock(a_p1_lock),
        .p0_cs_n(a_p0_cs_n), .p1_cs_n(a_p1_cs_n),
        .p0_start(a_p0_start), .p1_start(a_p1_start),
        .p0_txd(a_p0_txd), .p1_txd(a_p1_txd),
        .p0_rxd(a_p0_rxd), .p1_rxd(a_p1_rxd),
        .p0_done(a_p0_done), .p1_done(a_p1_done),
        .p0_gnt(a_p0_gnt), .p1_gnt(a_p1_gnt),
        .busy(a_busy), .spi_ss(a_ss), .spi_clk(a_clk), .spi_do(a_do), .spi_di(a_di)
    );

    // Instance B, CLK_DIV = 1, requester 1 unused
    logic       b_p0_lock = 0, b_p0_cs_n = 1, b_p0_start = 0;
    logic [7:0] b_p0_txd = 0;
    logic       b_zero = 0;
    logic [7:0] b_zero8 = 0;
    logic [7:0] b_p0_rxd, b_p1_rxd;
    logic       b_p0_done, b_p1_done, b_p0_gnt, b_p1_gnt, b_busy;
    logic       b_ss, b_clk, b_do;

    divmmc_spi_arbiter #(.CLK_DIV(1)) dut_b (
        .clk_sys(clk), .reset(reset),
        .p0_lock(b_p0_lock), .p1_lock(b_zero),
        .p0_cs_n(b_p0_cs_n), .p1_cs_n(b_zero),
        .p0_start(b_p0_start), .p1_start(b_zero),
        .p0_txd(b_p0_txd), .p1_txd(b_zero8),
        .p0_rxd(b_p0_rxd), .p1_rxd(b_p1_rxd),
        .p0_done(b_p0_done), .p1_done(b_p1_done),
        .p0_gnt(b_p0_gnt), .p1_gnt(b_p1_gnt),
        .busy(b_busy), .spi_ss(b_ss), .spi_clk(b_clk), .spi_do(b_do), .spi_di(b_do)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs n cycles on instance A, recording SCK rises, MOSI at each rise, high cycles and done pulses.
    // drop_at releases p1_lock, poke_at pulses both starts for one cycle.
    task automatic watch(input int n, input int drop_at, input int poke_at,
                         output int d0, output int d1, output int nd,
                         output int rises, output int highs, output logic [7:0] bits);
        logic prev;
        d0 = -1; d1 = -1; nd = 0; rises = 0; highs = 0; bits = 8'h00;
        prev = a_clk;
        for (int k = 1; k <= n; k++) begin
            tick();
            a_p0_start = 1'b0;
            a_p1_start = 1'b0;
            if (a_clk && !prev) begin
                rises++;
                bits = {bits[6:0], a_do};
            end
            if (a_clk) highs++;
            prev = a_clk;
            if (a_p0_done) begin nd++; if (d0 < 0) d0 = k; end
            if (a_p1_done) begin nd++; if (d1 < 0) d1 = k; end
            if (k == drop_at) a_p1_lock = 1'b0;
            if (k == poke_at) begin a_p0_start = 1'b1; a_p1_start = 1'b1; end
        end
    endtask

    int d0, d1, nd, rises, highs;
    logic [7:0] bits;
    int bd1, bd2;
    logic [7:0] brx1;

    initial begin
        tick(); tick();
        check("rst_rxd0", a_p0_rxd, 8'h00);
        check("rst_done0", a_p0_done, 0);
        check("rst_gnt", {a_p0_gnt, a_p1_gnt}, 0);
        check("rst_busy", a_busy, 0);
        check("rst_ss", a_ss, 1);
        check("rst_sclk", a_clk, 0);
        check("rst_do", a_do, 1);
        reset = 1'b0;
        tick();

        // Single p0 transfer of A5 with loopback
        a_p0_lock = 1; a_p0_cs_n = 0;
        tick();
        check("gnt0_latency", a_p0_gnt, 1);
        check("ss_follows_p0", a_ss, 0);
        a_p0_start = 1; a_p0_txd = 8'hA5;
        tick();
        a_p0_start = 0; a_p0_txd = 8'h00;
        check("busy_on_accept", a_busy, 1);
        check("first_bit", a_do, 1);
        watch(33, 0, 0, d0, d1, nd, rises, highs, bits);
        check("a5_done_at", d0, 32);
        check("a5_ndone", nd, 1);
        check("a5_rises", rises, 8);
        check("a5_highs", highs, 16);
        check("a5_mosi_bits", bits, 8'hA5);
        check("a5_rxd", a_p0_rxd, 8'hA5);
        check("a5_do_idle", a_do, 1);

        // Release p0, then simultaneous locks: p1 wins
        a_p0_lock = 0; a_p0_cs_n = 1;
        tick(); tick();
        a_p0_lock = 1; a_p1_lock = 1; a_p0_cs_n = 0;
        tick();
        check("prio_gnt", {a_p0_gnt, a_p1_gnt}, 2'b01);
        check("ss_p1_idle_cs", a_ss, 1);
        a_p1_cs_n = 0;
        #1;
        check("ss_zero_latency", a_ss, 0);
        a_p1_lock = 0; a_p1_cs_n = 1;
        tick();
        check("release_gnt", {a_p0_gnt, a_p1_gnt}, 2'b00);
        check("release_ss", a_ss, 1);
        tick();
        check("free_gnt0", a_p0_gnt, 0);
        check("free_ss", a_ss, 1);
        tick();
        check("regrant_p0", a_p0_gnt, 1);

        // Hand the bus to p1; p0 start while p1 owns and idle is dropped
        a_p0_lock = 0; a_p1_lock = 1; a_p0_cs_n = 1; a_p1_cs_n = 0;
        tick(); tick(); tick();
        check("own1", {a_p0_gnt, a_p1_gnt}, 2'b01);
        a_p0_start = 1; a_p0_txd = 8'h11;
        tick();
        a_p0_start = 0;
        watch(10, 0, 0, d0, d1, nd, rises, highs, bits);
        check("nonowner_rises", rises, 0);
        check("nonowner_ndone", nd, 0);
        check("nonowner_busy", a_busy, 0);
        check("nonowner_rxd", a_p0_rxd, 8'hA5);

        // p1 transfer with MISO low; extra starts while busy; lock dropped in bit 3
        a_loop = 0;
        a_p1_start = 1; a_p1_txd = 8'hFF;
        tick();
        a_p1_start = 0;
        watch(33, 13, 5, d0, d1, nd, rises, highs, bits);
        check("drop_done1_at", d1, 32);
        check("drop_ndone", nd, 1);
        check("drop_rises", rises, 8);
        check("drop_rxd1", a_p1_rxd, 8'h00);
        check("drop_rxd0_held", a_p0_rxd, 8'hA5);
        check("drop_release_gnt", a_p1_gnt, 0);
        check("drop_release_ss", a_ss, 1);

        // Reset during bit 5
        a_loop = 1; a_p1_cs_n = 1;
        a_p0_lock = 1; a_p0_cs_n = 0;
        tick(); tick();
        check("own0_again", a_p0_gnt, 1);
        a_p0_start = 1; a_p0_txd = 8'hFF;
        tick();
        a_p0_start = 0;
        watch(21, 0, 0, d0, d1, nd, rises, highs, bits);
        check("pre_reset_rises", rises, 5);
        reset = 1;
        #1;
        check("mid_rst_sclk", a_clk, 0);
        check("mid_rst_do", a_do, 1);
        check("mid_rst_ss", a_ss, 1);
        check("mid_rst_busy", a_busy, 0);
        check("mid_rst_gnt", {a_p0_gnt, a_p1_gnt}, 0);
        check("mid_rst_done", a_p0_done, 0);
        tick(); tick();
        reset = 0;
        watch(40, 0, 0, d0, d1, nd, rises, highs, bits);
        check("post_rst_ndone", nd, 0);
        check("post_rst_rises", rises, 0);
        check("post_rst_gnt", a_p0_gnt, 1);
        a_p0_start = 1; a_p0_txd = 8'h3C;
        tick();
        a_p0_start = 0; a_p0_txd = 8'hFF;
        watch(33, 0, 0, d0, d1, nd, rises, highs, bits);
        check("3c_done_at", d0, 32);
        check("3c_rxd", a_p0_rxd, 8'h3C);

        // CLK_DIV = 1 back-to-back bytes
        b_p0_lock = 1; b_p0_cs_n = 0;
        tick();
        check("b_gnt", b_p0_gnt, 1);
        b_p0_start = 1; b_p0_txd = 8'h5A;
        tick();
        b_p0_start = 0;
        bd1 = -1; bd2 = -1; brx1 = 8'h00;
        for (int k = 1; k <= 40; k++) begin
            tick();
            b_p0_start = 0;
            if (b_p0_done) begin
                if (bd1 < 0) begin
                    bd1 = k; brx1 = b_p0_rxd;
                    b_p0_start = 1; b_p0_txd = 8'hC3;
                end else if (bd2 < 0) begin
                    bd2 = k;
                end
            end
        end
        check("b_first_done", bd1, 16);
        check("b_spacing", bd2 - bd1, 17);
        check("b_rxd1", brx1, 8'h5A);
        check("b_rxd2", b_p0_rxd, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
